inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped, read-only instruction cache between the MIPS core's fetch port and the backing instruction memory. Hits return `inst` combinationally in the same cycle as `inst_addr`. Misses deassert `inst_valid`, which stalls the core. The line is then refilled one word per memory handshake, and fetch resumes on the cycle after the last beat.

## Interface
- `LINES`, 16: number of lines; power of 2, at least 2.
- `WORDS`, 4: 32-bit words per line; power of 2, at least 2.
- `clk`  in  1: the block's single clock; all state changes on its rising edge.
- `rst_b`  in  1: asynchronous, active-low reset.
- `inst_addr`  in  32: fetch byte address from the core; bits [1:0] ignored.
- `inst`  out  32: fetched instruction; 0 (MIPS NOP) whenever `inst_valid`=0.
- `inst_valid`  out  1: hit indication; the core stalls while low.
- `flush`  in  1: single-cycle pulse that invalidates every line.
- `mem_req`  out  1: read request to the backing memory.
- `mem_addr`  out  32: word-aligned read address.
- `mem_ready`  in  1: the beat is accepted and `mem_rdata` is valid in this cycle.
- `mem_rdata`  in  32: read data.
- `hit_count`, `miss_count`  out  32 each: present only with `INST_CACHE_PERF_EN`.

## Operation
Address fields:
- offset = addr[1+log2(WORDS):2]
- index = next log2(LINES) bits
- tag = the remaining upper bits

Storage per line:
- valid bit
- tag
- WORDS data words

Hit rule and output:
- Hit = valid[index] && tag match && state==IDLE.
- `inst` = data[index][offset] on a hit, else 0.

State machine:
- IDLE, on a miss: latch the line base address (tag, index, offset 0) and go to REFILL.
- REFILL: drive `mem_req`=1 and `mem_addr` = base + 4*beat.
  - On each cycle with `mem_ready`=1: write `mem_rdata` into data[index][beat], then increment beat.
  - On the last beat: write the tag, set valid unless a flush is pending, and return to IDLE.
- Handshake: once `mem_req` is high, it and `mem_addr` stay stable until `mem_ready`. `mem_req` never drops mid-line.
- `inst_addr` changing during REFILL has no effect on the refill. The core holds the address while stalled. If the new address misses, it is serviced after the current refill.

Flush:
- In IDLE: clears all valid bits at the edge.
- During REFILL: clears all valid bits and sets flush_pending. The refill runs to completion but leaves the line invalid. flush_pending clears on return to IDLE.
- Flush coincident with the last refill beat: the line stays invalid.

Reset, asserted asynchronously including mid-refill:
- All valid bits = 0.
- State = IDLE.
- `mem_req`=0, `mem_addr`=0, beat=0, flush_pending=0.
- Counters = 0.
- With all lines invalid, `inst`=0 and `inst_valid`=0.
- Data and tag arrays are not reset.

## Timing
- Hit: 0 cycles. `inst` and `inst_valid` are combinational from `inst_addr` and array state.
- Miss detected in cycle N: `mem_req` is high from N+1.
- With a zero-wait memory, beats are accepted in N+1..N+WORDS and the hit occurs in N+WORDS+1.
- Each memory wait cycle adds one cycle to the refill.
- `mem_addr` advances on the edge after an accepted beat.

## Configuration
`INST_CACHE_PERF_EN`:
- Defined:
  - `hit_count` increments on each IDLE cycle with a hit.
  - `miss_count` increments once per IDLE-to-REFILL transition.
  - Both are 32 bits, wrap from 0xFFFF_FFFF to 0, and reset to 0.
- Undefined: both ports and both counters are absent. All other behaviour is identical.

## Structure
- `inst_cache_pkg` holds:
  - state enum (IDLE, REFILL)
  - localparam helpers for offset, index and tag widths derived from `LINES`/`WORDS`
  - the NOP constant 32'h0000_0000
- Sub-module `inst_cache_refill`: the FSM, beat counter, flush_pending and memory handshake. It outputs write-enable, write index and beat to the arrays, which live in `inst_cache`.

## Test plan
- Cold miss, default parameters, zero-wait memory, `inst_addr`=0x0000_0040, miss in cycle 0:
  - `inst_valid`=0 and `inst`=0.
  - `mem_addr` = 0x40, 0x44, 0x48, 0x4C in cycles 1–4.
  - In cycle 5, `inst_valid`=1 and `inst` = the word returned for 0x40.
- Following that refill, `inst_addr`=0x4C → same-cycle hit returning the fourth beat's data, with `mem_req`=0.
- Conflict, following the cold miss: fetch 0x0000_0140 (index 4, different tag) → miss and refill from 0x140; a re-fetch of 0x40 then misses.
- Wait states: `mem_ready` high every other cycle → `mem_addr` is held across low cycles, 8 cycles of REFILL, hit in cycle 9.
- Flush pulsed at the second beat → all 4 beats are still requested, the line is left invalid, and the next fetch of the same address misses.
- `rst_b` low during beat 2 → `mem_req` falls without waiting for a clock edge.
- Reset release: the first fetch misses. With `INST_CACHE_PERF_EN`, after the sequence miss, hit, hit: `hit_count`=2 and `miss_count`=1.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// ---------------------------------------------------------------------------
// inst_cache_pkg
// Shared types and width helpers for the direct-mapped instruction cache.
//   state_t   : refill controller states (IDLE, REFILL)
//   NOP       : value driven on the instruction port while the core is stalled
//   offset_w  : word-offset field width for a given words-per-line count
//   index_w   : line-index field width for a given line count
//   tag_w     : tag field width (32-bit byte address, bits [1:0] unused)
// ---------------------------------------------------------------------------
package inst_cache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic int offset_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/inst_cache_refill.sv
// ---------------------------------------------------------------------------
// inst_cache_refill
// Line-refill controller: FSM, beat counter, pending-flush flag and the
// backing-memory read handshake. The arrays live in the parent.
// Ports:
//   clk, rst_b     : clock, asynchronous active-low reset
//   miss           : lookup missed (only acted on in IDLE)
//   line_addr      : tag+index bits of the fetch address (latched on a miss)
//   flush          : invalidate-all pulse
//   mem_ready      : memory accepted the current beat, read data valid
//   idle           : controller in IDLE (lookups may hit)
//   mem_req/addr   : memory read request and word-aligned address
//   wr_en          : write the current beat into the data array
//   wr_index/beat  : array coordinates of the beat being written
//   wr_tag         : tag of the line being refilled
//   fill_done      : last beat accepted this cycle
//   set_valid      : last beat and no flush seen during this refill
// ---------------------------------------------------------------------------
module inst_cache_refill
    import inst_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           miss,
    input  logic [29-offset_w(WORDS):0]    line_addr,
    input  logic                           flush,
    input  logic                           mem_ready,
    output logic                           idle,
    output logic                           mem_req,
    output logic [31:0]                    mem_addr,
    output logic                           wr_en,
    output logic [index_w(LINES)-1:0]      wr_index,
    output logic [offset_w(WORDS)-1:0]     wr_beat,
    output logic [tag_w(LINES, WORDS)-1:0] wr_tag,
    output logic                           fill_done,
    output logic                           set_valid
);
    localparam int OW = offset_w(WORDS);
    localparam int IW = index_w(LINES);

    state_t         state_q, state_d;
    logic [OW-1:0]  beat_q, beat_d;
    logic           flush_pending_q, flush_pending_d;
    logic [29-OW:0] line_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Only observed while in REFILL, and always captured on entry, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && miss) begin
            line_q <= line_addr;
        end
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        flush_pending_d = flush_pending_q;
        idle            = 1'b0;
        mem_req         = 1'b0;
        mem_addr        = NOP;
        wr_en           = 1'b0;
        fill_done       = 1'b0;
        set_valid       = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle = 1'b1;
                if (miss) begin
                    state_d = REFILL;
                    beat_d  = '0;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                // Base address has offset 0, so base + 4*beat is a concatenation.
                mem_addr = {line_q, beat_q, 2'b00};
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_ready) begin
                    wr_en  = 1'b1;
                    // Power-of-two line length: the counter wraps to 0 on the last beat.
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        fill_done       = 1'b1;
                        set_valid       = !flush_pending_q && !flush;
                        state_d         = IDLE;
                        flush_pending_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_index = line_q[IW-1:0];
    assign wr_tag   = line_q[29-OW:IW];
    assign wr_beat  = beat_q;

endmodule

// File: rtl/inst_cache.sv
// ---------------------------------------------------------------------------
// inst_cache
// Direct-mapped, read-only instruction cache between the core fetch port and
// the backing instruction memory. Hits are combinational; a miss stalls the
// core (inst_valid=0) while the line is refilled one word per handshake.
// Ports:
//   clk, rst_b            : clock, asynchronous active-low reset
//   inst_addr             : fetch byte address (bits [1:0] ignored)
//   inst, inst_valid      : fetched instruction (NOP when not valid), hit flag
//   flush                 : single-cycle invalidate-all pulse
//   mem_req, mem_addr     : read request / word address to backing memory
//   mem_ready, mem_rdata  : beat accepted / read data
//   hit_count, miss_count : performance counters, only with INST_CACHE_PERF_EN
// Build option: define INST_CACHE_PERF_EN to add the hit/miss counters.
// ---------------------------------------------------------------------------
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef INST_CACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int OW = offset_w(WORDS);
    localparam int IW = index_w(LINES);
    localparam int TW = tag_w(LINES, WORDS);

    logic [OW-1:0]    offset;
    logic [IW-1:0]    index;
    logic [TW-1:0]    tag;
    logic [1:0]       unused_byte_bits;

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_arr  [LINES];
    logic [31:0]      data_arr [LINES][WORDS];

    logic             lookup_hit;
    logic             hit;
    logic             idle;
    logic             wr_en;
    logic [IW-1:0]    wr_index;
    logic [OW-1:0]    wr_beat;
    logic [TW-1:0]    wr_tag;
    logic             fill_done;
    logic             set_valid;

    assign offset           = inst_addr[OW+1:2];
    assign index            = inst_addr[OW+IW+1:OW+2];
    assign tag              = inst_addr[31:OW+IW+2];
    assign unused_byte_bits = inst_addr[1:0];

    assign lookup_hit = valid_q[index] && (tag_arr[index] == tag);
    assign hit        = idle && lookup_hit;
    assign inst_valid = hit;
    assign inst       = hit ? data_arr[index][offset] : NOP;

    inst_cache_refill #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_refill (
        .clk       (clk),
        .rst_b     (rst_b),
        .miss      (!lookup_hit),
        .line_addr (inst_addr[31:OW+2]),
        .flush     (flush),
        .mem_ready (mem_ready),
        .idle      (idle),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_beat   (wr_beat),
        .wr_tag    (wr_tag),
        .fill_done (fill_done),
        .set_valid (set_valid)
    );

    // Flush wins over a completing refill so the line stays invalid.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_arr[wr_index][wr_beat] <= mem_rdata;
        end
        if (fill_done) begin
            tag_arr[wr_index] <= wr_tag;
        end
    end

`ifdef INST_CACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            // A miss seen in IDLE is exactly the IDLE-to-REFILL transition.
            if (idle && !lookup_hit) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// ---------------------------------------------------------------------------
// tb_inst_cache
// Self-checking bench for inst_cache (default LINES=16, WORDS=4).
// A reference model (per-line valid/tag arrays plus a fixed memory-content
// function) predicts hit/miss, returned data, stall length and the sequence
// of refill addresses; a monitor compares the DUT against those queues.
// Build option: define INST_CACHE_PERF_EN to also check hit/miss counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_cache;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int OW    = 2;
    localparam int IW    = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef INST_CACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    inst_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .inst_addr  (inst_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
`ifdef INST_CACHE_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // ---------------- counters and comparison helper ----------------
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- memory model ----------------
    // Odd multiplier makes every word address map to distinct data.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    int          mode = 0;      // 0: zero-wait, 1: ready every other cycle, 2: random
    logic        ready_en = 1'b0;
    logic [31:0] junk = 32'h0;
    int          refill_cyc = 0;
    int          flush_cd = -1; // flush is asserted in the cycle this reaches 0

    assign mem_ready = ready_en & mem_req;
    assign mem_rdata = mem_ready ? mem_word(mem_addr) : junk;

    initial forever begin
        @(posedge clk);
        #1;
        junk = $urandom;
        if (mem_req) refill_cyc++;
        else refill_cyc = 0;
        case (mode)
            0:       ready_en = 1'b1;
            1:       ready_en = (refill_cyc % 2 == 0);
            default: ready_en = ($urandom_range(0, 2) != 0);
        endcase
        #1;
        flush = (flush_cd == 0);
        if (flush_cd >= 0) flush_cd--;
    end

    // ---------------- reference model and scoreboard queues ----------------
    typedef struct {
        logic [31:0] data;
        int          stalls;   // -1: any nonzero stall is acceptable
    } exp_t;

    exp_t        txq[$];
    logic [31:0] addrq[$];
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    // Call just after a rising edge. fcd: -1 none, 0 flush with the fetch,
    // k>=1 flush during refill cycle k (zero-wait mode only).
    task automatic fetch(input logic [31:0] a, input int fcd);
        int          ix;
        logic [31:0] tg;
        logic [31:0] base;
        bit          miss;
        int          refills;
        int          n;
        exp_t        e;
        ix   = int'((a >> (2 + OW)) % LINES);
        tg   = a >> (2 + OW + IW);
        base = a & ~32'(WORDS * 4 - 1);
        miss = !(mvalid[ix] && mtag[ix] == tg);
        refills = !miss ? 0 : (fcd >= 1 ? 2 : 1);
        if (fcd >= 0) model_clear();
        for (int r = 0; r < refills; r++)
            for (int b = 0; b < WORDS; b++) addrq.push_back(base + 32'(4 * b));
        if (miss) begin
            mvalid[ix] = 1'b1;
            mtag[ix]   = tg;
        end
        e.data   = mem_word(a & ~32'h3);
        e.stalls = !miss ? 0 : (mode == 0 ? refills * (1 + WORDS) :
                                mode == 1 ? refills * (1 + 2 * WORDS) : -1);
        txq.push_back(e);
        exp_misses += refills;
        inst_addr = a;
        flush_cd  = fcd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 300);
        if (!inst_valid) begin
            fail("fetch_timeout");
            txq.delete();
            addrq.delete();
        end else begin
            exp_hits++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int   stalls = 0;
    exp_t mon_e;

    initial forever begin
        @(negedge clk);
        if (!rst_b) begin
            stalls = 0;
        end else begin
            if (mem_req) begin
                if (addrq.size() == 0) fail("unexpected_mem_req");
                else begin
                    check("mem_addr", mem_addr, addrq[0]);
                    if (mem_ready) void'(addrq.pop_front());
                end
            end
            if (inst_valid) begin
                check("mem_req_on_hit", {31'b0, mem_req}, 32'd0);
                if (txq.size() == 0) fail("unexpected_inst_valid");
                else begin
                    mon_e = txq.pop_front();
                    check("inst", inst, mon_e.data);
                    if (mon_e.stalls >= 0) check("stall_cycles", stalls, mon_e.stalls);
                    else check("stall_nonzero", {31'b0, stalls > 0}, 32'd1);
                end
                stalls = 0;
            end else begin
                check("nop_when_stalled", inst, 32'h0);
                if (txq.size() != 0) stalls++;
            end
        end
    end

    task automatic check_perf();
`ifdef INST_CACHE_PERF_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif
    endtask

    // ---------------- stimulus ----------------
    logic [23:0] tags [3] = '{24'h000000, 24'h000001, 24'hABCDEF};

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("reset_inst", inst, 32'h0);
        check("reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check_perf();
        rst_b = 1'b1;

        // Cold miss, hit in same line, conflict eviction, re-miss.
        mode = 0;
        fetch(32'h0000_0040, -1);
        fetch(32'h0000_004C, -1);
        fetch(32'h0000_0140, -1);
        fetch(32'h0000_0040, -1);

        // Wait states: ready every other cycle.
        mode = 1;
        fetch(32'h0000_0080, -1);
        fetch(32'h0000_0084, -1);

        // Flush at second beat, flush on last beat, flush in IDLE with a hit.
        mode = 0;
        fetch(32'h0000_0200, 2);
        fetch(32'h0000_0300, WORDS);
        fetch(32'h0000_0304, 0);
        fetch(32'h0000_0308, -1);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            mode = $urandom_range(0, 2);
            a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            fetch(a, ($urandom_range(0, 11) == 0) ? 0 : -1);
        end
        check_perf();

        // Asynchronous reset during beat 2 of a refill.
        mode = 0;
        inst_addr = 32'h0000_0500;
        for (int b = 0; b < WORDS; b++) addrq.push_back(32'h0000_0500 + 32'(4 * b));
        repeat (3) @(posedge clk);
        #3;
        rst_b = 1'b0;
        txq.delete();
        addrq.delete();
        #1;
        check("async_reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("async_reset_mem_addr", mem_addr, 32'h0);
        check("async_reset_inst_valid", {31'b0, inst_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold_mem_req", {31'b0, mem_req}, 32'd0);
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        rst_b = 1'b1;
        fetch(32'h0000_004C, -1);
        fetch(32'h0000_0048, -1);
        check_perf();

        check("txq_drained", 32'(txq.size()), 32'd0);
        check("addrq_drained", 32'(addrq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
